pong_game_ctrl: RTL and testbench

- Game-level sequencer for the VGA ping-pong design.
- Sits beside the ball/paddle graphics datapath and the text overlay, one level below the top wrapper.
- Consumes hit/miss events from the graphics block, button presses and a once-per-frame refresh tick.
- Produces the freeze control for the graphics datapath, the overlay-select code, the BCD score and the balls-remaining count.

---
 rtl/pong_pkg.sv | 31 +++
 rtl/pong_bcd_counter.sv | 43 ++++
 rtl/pong_game_ctrl.sv | 138 +++++++++++++
 tb/tb_pong_game_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared encodings and defaults for the ping-pong game sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_NEWGAME = 3'd0,
    ST_PLAY    = 3'd1,
    ST_NEWBALL = 3'd2,
    ST_OVER    = 3'd3,
    ST_PAUSE   = 3'd5
  } state_e;

  localparam logic [1:0] TXT_RULE  = 2'b00;
  localparam logic [1:0] TXT_SCORE = 2'b01;
  localparam logic [1:0] TXT_OVER  = 2'b10;

  localparam int BALLS_DEFAULT       = 3;
  localparam int TIMER_TICKS_DEFAULT = 120;

  // PAUSE reports itself as PLAY on the two-bit debug code.
  function automatic logic [1:0] state_code(input state_e s);
    case (s)
      ST_NEWGAME: state_code = 2'd0;
      ST_PLAY:    state_code = 2'd1;
      ST_NEWBALL: state_code = 2'd2;
      ST_OVER:    state_code = 2'd3;
      ST_PAUSE:   state_code = 2'd1;
      default:    state_code = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pong_bcd_counter.sv
// Two-digit BCD score counter: clear wins over increment, 99 wraps to 00.
module pong_bcd_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [3:0] d1_o,
  output logic [3:0] d0_o
);

  logic [3:0] d1_q, d1_d;
  logic [3:0] d0_q, d0_d;

  always_comb begin
    d1_d = d1_q;
    d0_d = d0_q;
    if (clr_i) begin
      d1_d = 4'd0;
      d0_d = 4'd0;
    end else if (inc_i) begin
      if (d0_q == 4'd9) begin
        d0_d = 4'd0;
        d1_d = (d1_q == 4'd9) ? 4'd0 : d1_q + 4'd1;
      end else begin
        d0_d = d0_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d1_q <= 4'd0;
      d0_q <= 4'd0;
    end else begin
      d1_q <= d1_d;
      d0_q <= d0_d;
    end
  end

  assign d1_o = d1_q;
  assign d0_o = d0_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-level sequencer: start, play, ball hold, game over; registered outputs.
// Optional PAUSE state on a rising edge of both buttons when PONG_PAUSE_EN is defined.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS       = BALLS_DEFAULT,
  parameter int TIMER_TICKS = TIMER_TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       refr_tick,
  input  logic       hit,
  input  logic       miss,
  output logic       graph_still,
  output logic [1:0] text_sel,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [2:0] ball_left,
  output logic [1:0] game_state
);

  localparam logic [2:0] BALLS_W = 3'(BALLS);
  localparam logic [6:0] TICKS_W = 7'(TIMER_TICKS);

  state_e     state_q;
  logic [2:0] ball_left_q;
  logic [6:0] timer_q;
  logic       graph_still_q;
  logic [1:0] text_sel_q;
  logic       score_inc;
  logic       score_clr;

`ifdef PONG_PAUSE_EN
  logic [1:0] btn_q;
  logic       pause_edge;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_q <= 2'b00;
    else        btn_q <= btn;
  end

  assign pause_edge = (btn == 2'b11) && (btn_q != 2'b11);
  assign score_inc  = hit && (state_q == ST_PLAY) && !pause_edge;
`else
  assign score_inc  = hit && (state_q == ST_PLAY);
`endif
  assign score_clr  = (state_q == ST_OVER) && (timer_q == 7'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_NEWGAME;
      ball_left_q   <= BALLS_W;
      timer_q       <= 7'd0;
      graph_still_q <= 1'b1;
      text_sel_q    <= TXT_RULE;
    end else begin
      case (state_q)
        ST_NEWGAME: begin
          if (btn != 2'b00) begin
            state_q       <= ST_PLAY;
            ball_left_q   <= ball_left_q - 3'd1;
            graph_still_q <= 1'b0;
            text_sel_q    <= TXT_SCORE;
          end
        end
        ST_PLAY: begin
`ifdef PONG_PAUSE_EN
          if (pause_edge) begin
            state_q       <= ST_PAUSE;
            graph_still_q <= 1'b1;
          end else
`endif
          // A coincident hit is scored by the counter in the same cycle.
          if (miss) begin
            timer_q       <= TICKS_W;
            graph_still_q <= 1'b1;
            if (ball_left_q == 3'd0) begin
              state_q    <= ST_OVER;
              text_sel_q <= TXT_OVER;
            end else begin
              state_q     <= ST_NEWBALL;
              ball_left_q <= ball_left_q - 3'd1;
            end
          end
        end
        ST_NEWBALL: begin
          if (timer_q == 7'd0) begin
            if (btn != 2'b00) begin
              state_q       <= ST_PLAY;
              graph_still_q <= 1'b0;
            end
          end else if (refr_tick) begin
            timer_q <= timer_q - 7'd1;
          end
        end
        ST_OVER: begin
          if (timer_q == 7'd0) begin
            state_q       <= ST_NEWGAME;
            ball_left_q   <= BALLS_W;
            graph_still_q <= 1'b1;
            text_sel_q    <= TXT_RULE;
          end else if (refr_tick) begin
            timer_q <= timer_q - 7'd1;
          end
        end
`ifdef PONG_PAUSE_EN
        ST_PAUSE: begin
          if (pause_edge) begin
            state_q       <= ST_PLAY;
            graph_still_q <= 1'b0;
          end
        end
`endif
        default: begin
          state_q       <= ST_NEWGAME;
          graph_still_q <= 1'b1;
          text_sel_q    <= TXT_RULE;
        end
      endcase
    end
  end

  pong_bcd_counter u_score (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (score_clr),
    .inc_i  (score_inc),
    .d1_o   (score_d1),
    .d0_o   (score_d0)
  );

  assign graph_still = graph_still_q;
  assign text_sel    = text_sel_q;
  assign ball_left   = ball_left_q;
  assign game_state  = state_code(state_q);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: start, scoring, wrap, ball hold, game over, reset.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       refr_tick = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       graph_still;
  logic [1:0] text_sel;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [2:0] ball_left;
  logic [1:0] game_state;

  int checks = 0;
  int passed = 0;
  int score_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .refr_tick   (refr_tick),
    .hit         (hit),
    .miss        (miss),
    .graph_still (graph_still),
    .text_sel    (text_sel),
    .score_d1    (score_d1),
    .score_d0    (score_d0),
    .ball_left   (ball_left),
    .game_state  (game_state)
  );

  function automatic logic [7:0] bcd_of(input int n);
    bcd_of = {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic refr_ticks(input int n);
    repeat (n) begin
      refr_tick = 1'b1; step(1);
      refr_tick = 1'b0; step(1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);
    checks++; if (game_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", game_state); else passed++;
    checks++; if (graph_still !== 1'b1) $display("FAIL reset_still: got %0b expected 1", graph_still); else passed++;
    checks++; if (text_sel !== 2'b00) $display("FAIL reset_text: got %0d expected 0", text_sel); else passed++;
    checks++; if ({score_d1, score_d0} !== 8'h00) $display("FAIL reset_score: got %h expected 00", {score_d1, score_d0}); else passed++;
    checks++; if (ball_left !== 3'd3) $display("FAIL reset_balls: got %0d expected 3", ball_left); else passed++;
  endtask

  task automatic test_start_and_hits;
    btn = 2'b01; step(1); btn = 2'b00;
    checks++; if (game_state !== 2'd1) $display("FAIL start_state: got %0d expected 1", game_state); else passed++;
    checks++; if (ball_left !== 3'd2) $display("FAIL start_balls: got %0d expected 2", ball_left); else passed++;
    checks++; if (graph_still !== 1'b0) $display("FAIL start_still: got %0b expected 0", graph_still); else passed++;
    checks++; if (text_sel !== 2'b01) $display("FAIL start_text: got %0d expected 1", text_sel); else passed++;
    for (int i = 0; i < 5; i++) begin
      score_cnt = (score_cnt + 1) % 100;
      exp_q.push_back(bcd_of(score_cnt));
      hit = 1'b1; step(1); hit = 1'b0;
      exp_v = exp_q.pop_front();
      checks++; if ({score_d1, score_d0} !== exp_v) $display("FAIL hit_score: got %h expected %h", {score_d1, score_d0}, exp_v); else passed++;
      step(1);
    end
    checks++; if ({score_d1, score_d0} !== 8'h05) $display("FAIL five_hits: got %h expected 05", {score_d1, score_d0}); else passed++;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 95; i++) begin
      score_cnt = (score_cnt + 1) % 100;
      exp_q.push_back(bcd_of(score_cnt));
      hit = 1'b1; step(1); hit = 1'b0;
      exp_v = exp_q.pop_front();
      checks++; if ({score_d1, score_d0} !== exp_v) $display("FAIL wrap_seq: got %h expected %h", {score_d1, score_d0}, exp_v); else passed++;
      if (i == 93) begin
        checks++; if ({score_d1, score_d0} !== 8'h99) $display("FAIL score_99: got %h expected 99", {score_d1, score_d0}); else passed++;
      end
      step(1);
    end
    checks++; if ({score_d1, score_d0} !== 8'h00) $display("FAIL score_wrap: got %h expected 00", {score_d1, score_d0}); else passed++;
  endtask

  task automatic test_hit_miss_newball;
    hit = 1'b1; miss = 1'b1; refr_tick = 1'b1; step(1);
    hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
    checks++; if ({score_d1, score_d0} !== 8'h01) $display("FAIL hm_score: got %h expected 01", {score_d1, score_d0}); else passed++;
    checks++; if (ball_left !== 3'd1) $display("FAIL hm_balls: got %0d expected 1", ball_left); else passed++;
    checks++; if (game_state !== 2'd2) $display("FAIL hm_state: got %0d expected 2", game_state); else passed++;
    checks++; if (graph_still !== 1'b1) $display("FAIL hm_still: got %0b expected 1", graph_still); else passed++;
    refr_ticks(119);
    btn = 2'b10; step(1); btn = 2'b00;
    checks++; if (game_state !== 2'd2) $display("FAIL nb_early_btn: got %0d expected 2", game_state); else passed++;
    refr_ticks(1);
    step(3);
    checks++; if (game_state !== 2'd2) $display("FAIL nb_idle: got %0d expected 2", game_state); else passed++;
    btn = 2'b10; step(1); btn = 2'b00;
    checks++; if (game_state !== 2'd1) $display("FAIL nb_resume: got %0d expected 1", game_state); else passed++;
    checks++; if (graph_still !== 1'b0) $display("FAIL nb_resume_still: got %0b expected 0", graph_still); else passed++;
  endtask

  task automatic test_game_over;
    miss = 1'b1; step(1); miss = 1'b0;
    checks++; if (ball_left !== 3'd0) $display("FAIL last_ball: got %0d expected 0", ball_left); else passed++;
    btn = 2'b01;
    refr_ticks(119);
    checks++; if (game_state !== 2'd2) $display("FAIL held_btn_wait: got %0d expected 2", game_state); else passed++;
    refr_ticks(1);
    btn = 2'b00;
    checks++; if (game_state !== 2'd1) $display("FAIL held_btn_go: got %0d expected 1", game_state); else passed++;
    miss = 1'b1; step(1); miss = 1'b0;
    checks++; if (game_state !== 2'd3) $display("FAIL over_state: got %0d expected 3", game_state); else passed++;
    checks++; if (text_sel !== 2'b10) $display("FAIL over_text: got %0d expected 2", text_sel); else passed++;
    hit = 1'b1; step(1); hit = 1'b0;
    checks++; if ({score_d1, score_d0} !== 8'h01) $display("FAIL over_score_kept: got %h expected 01", {score_d1, score_d0}); else passed++;
    refr_ticks(119);
    checks++; if (game_state !== 2'd3) $display("FAIL over_wait: got %0d expected 3", game_state); else passed++;
    refr_ticks(1);
    checks++; if (game_state !== 2'd0) $display("FAIL over_done: got %0d expected 0", game_state); else passed++;
    checks++; if ({score_d1, score_d0} !== 8'h00) $display("FAIL over_clr: got %h expected 00", {score_d1, score_d0}); else passed++;
    checks++; if (ball_left !== 3'd3) $display("FAIL over_reload: got %0d expected 3", ball_left); else passed++;
    checks++; if (text_sel !== 2'b00) $display("FAIL over_rule_text: got %0d expected 0", text_sel); else passed++;
  endtask

  task automatic test_reset_mid_newball;
    btn = 2'b11; step(1); btn = 2'b00;
    checks++; if (game_state !== 2'd1) $display("FAIL both_btn_start: got %0d expected 1", game_state); else passed++;
    step(1);
    hit = 1'b1; step(1); hit = 1'b0;
    miss = 1'b1; step(1); miss = 1'b0;
    refr_ticks(60);
    checks++; if (game_state !== 2'd2) $display("FAIL mid_nb_state: got %0d expected 2", game_state); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (game_state !== 2'd0) $display("FAIL async_state: got %0d expected 0", game_state); else passed++;
    checks++; if ({score_d1, score_d0} !== 8'h00) $display("FAIL async_score: got %h expected 00", {score_d1, score_d0}); else passed++;
    checks++; if (ball_left !== 3'd3) $display("FAIL async_balls: got %0d expected 3", ball_left); else passed++;
    checks++; if (graph_still !== 1'b1 || text_sel !== 2'b00) $display("FAIL async_ctrl: got %0b/%0d expected 1/0", graph_still, text_sel); else passed++;
    step(1);
    reset = 1'b1;
    step(2);
    checks++; if (game_state !== 2'd0) $display("FAIL post_reset_state: got %0d expected 0", game_state); else passed++;
  endtask

`ifdef PONG_PAUSE_EN
  task automatic test_pause;
    btn = 2'b01; step(1); btn = 2'b00; step(1);
    btn = 2'b11; step(1);
    checks++; if (graph_still !== 1'b1 || game_state !== 2'd1) $display("FAIL pause_enter: got %0b/%0d expected 1/1", graph_still, game_state); else passed++;
    hit = 1'b1; step(1); hit = 1'b0;
    checks++; if ({score_d1, score_d0} !== 8'h00) $display("FAIL pause_hit: got %h expected 00", {score_d1, score_d0}); else passed++;
    btn = 2'b00; step(1);
    btn = 2'b11; step(1); btn = 2'b00;
    checks++; if (graph_still !== 1'b0) $display("FAIL pause_exit: got %0b expected 0", graph_still); else passed++;
    hit = 1'b1; step(1); hit = 1'b0;
    checks++; if ({score_d1, score_d0} !== 8'h01) $display("FAIL pause_resume_hit: got %h expected 01", {score_d1, score_d0}); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_start_and_hits();
    test_wrap();
    test_hit_miss_newball();
    test_game_over();
    test_reset_mid_newball();
`ifdef PONG_PAUSE_EN
    test_pause();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
